// File: rtl/ofm_pingpong_buffer.sv
// Ping-pong output-feature-map staging buffer: two banks alternate between filling from the
// datapath and draining as a valid/ready stream with a per-burst last marker.
module ofm_pingpong_buffer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   burst_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [1:0]        bank_full,
    output logic              overflow
);

    localparam logic [ADDR_W:0] LenMax = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LenOne = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem [2*DEPTH];

    logic                   wb_q, wb_d, rb_q, rb_d, rel_q, rel_d;
    logic [ADDR_W-1:0]      wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [1:0][ADDR_W:0]   len_q, len_d;
    logic [1:0]             bank_full_q, bank_full_d;
    logic [1:0]             rd_done_q, rd_done_d;
    logic                   overflow_q, overflow_d;
    logic                   rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
    logic [DATA_W-1:0]      rd_data_q;
    logic [1:0][DATA_W-1:0] fdata_q, fdata_d;
    logic [1:0]             flast_q, flast_d;
    logic [1:0]             fcnt_q, fcnt_d, fcnt_n;

    logic [ADDR_W:0] len_sat, wlen;
    logic            wr_en, wr_end, rd_en, rd_last, room, pop, rel;

    assign len_sat  = (burst_len == '0 || burst_len > LenMax) ? LenMax : burst_len;
    // A fresh bank completes against the length being latched this cycle.
    assign wlen     = (wcnt_q == '0) ? len_sat : len_q[wb_q];
    assign in_ready = ~rst & ~bank_full_q[wb_q];
    assign wr_en    = in_valid & in_ready;
    assign wr_end   = wr_en && ({1'b0, wcnt_q} == wlen - LenOne);

    assign pop     = (fcnt_q != 2'd0) & out_ready;
    assign rel     = pop & flast_q[0];
    // Issue only if FIFO entries plus in-flight reads, after this cycle's pop, leave a slot.
    assign room    = (3'(fcnt_q) + 3'(rd_vld_q)) <= (3'(pop) + 3'd1);
    assign rd_en   = bank_full_q[rb_q] & ~rd_done_q[rb_q] & room;
    assign rd_last = ({1'b0, rcnt_q} == len_q[rb_q] - LenOne);

    assign out_valid = (fcnt_q != 2'd0);
    assign out_data  = fdata_q[0];
    assign out_last  = flast_q[0] & out_valid;
    assign bank_full = bank_full_q;
    assign overflow  = overflow_q;

    always_comb begin
        wb_d        = wb_q;
        rb_d        = rb_q;
        rel_d       = rel_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        len_d       = len_q;
        bank_full_d = bank_full_q;
        rd_done_d   = rd_done_q;
        overflow_d  = overflow_q | (in_valid & ~in_ready);
        rd_vld_d    = rd_en;
        rd_last_d   = rd_en & rd_last;

        if (wr_en) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == '0) len_d[wb_q] = len_sat;
            if (wr_end) begin
                bank_full_d[wb_q] = 1'b1;
                wcnt_d            = '0;
                wb_d              = ~wb_q;
            end
        end

        if (rd_en) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rd_last) begin
                rcnt_d          = '0;
                rb_d            = ~rb_q;
                rd_done_d[rb_q] = 1'b1;
            end
        end

        // Banks drain in strict alternation, so the released bank is tracked by a toggle.
        if (rel) begin
            bank_full_d[rel_q] = 1'b0;
            rd_done_d[rel_q]   = 1'b0;
            rel_d              = ~rel_q;
        end

        fdata_d = fdata_q;
        flast_d = flast_q;
        fcnt_n  = fcnt_q;
        if (pop) begin
            fdata_d[0] = fdata_q[1];
            flast_d[0] = flast_q[1];
            fcnt_n     = fcnt_q - 2'd1;
        end
        if (rd_vld_q) begin
            fdata_d[fcnt_n[0]] = rd_data_q;
            flast_d[fcnt_n[0]] = rd_last_q;
            fcnt_n             = fcnt_n + 2'd1;
        end
        fcnt_d = fcnt_n;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wb_q, wcnt_q}] <= in_data;
        if (rd_en) rd_data_q <= mem[{rb_q, rcnt_q}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            rel_q       <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            len_q       <= '0;
            bank_full_q <= 2'b00;
            rd_done_q   <= 2'b00;
            overflow_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            fdata_q     <= '0;
            flast_q     <= 2'b00;
            fcnt_q      <= 2'd0;
        end else begin
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            rel_q       <= rel_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            len_q       <= len_d;
            bank_full_q <= bank_full_d;
            rd_done_q   <= rd_done_d;
            overflow_q  <= overflow_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            fdata_q     <= fdata_d;
            flast_q     <= flast_d;
            fcnt_q      <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_ofm_pingpong_buffer.sv
// Scoreboard bench for ofm_pingpong_buffer: accepted input words are queued with their
// expected last flag and compared against every valid output cycle.
module tb_ofm_pingpong_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  burst_len;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic [1:0]  bank_full;
    logic        overflow;

    logic rand_rdy, rdy_force, rnd_bit;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   mcnt  = 0;
    int   mlen  = 16;

    ofm_pingpong_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .burst_len (burst_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .bank_full (bank_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    assign out_ready = rand_rdy ? rnd_bit : rdy_force;

    always @(posedge clk) begin
        cyc++;
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output checks and input capture both happen half a cycle before the edge they describe.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_valid_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    check_eq("out_data", out_data, exp_q[0].data);
                    check_eq("out_last", 64'(out_last), 64'(exp_q[0].last));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pop_cyc.push_back(cyc);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (mcnt == 0) mlen = (burst_len == 0 || burst_len > 16) ? 16 : int'(burst_len);
                exp_q.push_back({in_data, 1'(mcnt == mlen - 1)});
                mcnt = (mcnt == mlen - 1) ? 0 : mcnt + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [63:0] base, input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (!in_ready) begin
                in_valid = 1'b0;
                tick(1);
                guard++;
                if (guard > 300) begin
                    check_eq("in_ready_wait", 64'(in_ready), 64'd1);
                    return;
                end
            end
            in_valid = 1'b1;
            in_data  = base + 64'(i);
            tick(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 500) begin
            tick(1);
            g++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int g;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        burst_len = 5'd16;
        rdy_force = 1'b0;
        rand_rdy  = 1'b0;
        #1;
        check_eq("in_ready_in_rst", 64'(in_ready), 64'd0);
        tick(2);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_last", 64'(out_last), 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_bank_full", 64'(bank_full), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);

        // 16-word burst, latency from bank full to out_valid
        pop_cyc.delete();
        push_words(64'h0, 16);
        check_eq("t1_full", 64'(bank_full), 64'd1);
        check_eq("t1_valid_t0", 64'(out_valid), 64'd0);
        tick(1);
        check_eq("t1_valid_t1", 64'(out_valid), 64'd0);
        tick(1);
        check_eq("t1_valid_t2", 64'(out_valid), 64'd1);
        rdy_force = 1'b1;
        wait_drain("t1_drain");
        check_eq("t1_released", 64'(bank_full), 64'd0);
        check_eq("t1_count", 64'(pop_cyc.size()), 64'd16);

        // short bursts, zero bubble across the bank boundary
        pop_cyc.delete();
        burst_len = 5'd4;
        push_words(64'h100, 12);
        wait_drain("t2_drain");
        check_eq("t2_count", 64'(pop_cyc.size()), 64'd12);
        if (pop_cyc.size() >= 8) check_eq("t2_contiguous", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);
        check_eq("t2_overflow", 64'(overflow), 64'd0);

        // both banks full, overrun, release timing
        pop_cyc.delete();
        rdy_force = 1'b0;
        burst_len = 5'd16;
        push_words(64'h200, 32);
        check_eq("t3_both_full", 64'(bank_full), 64'd3);
        check_eq("t3_in_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        tick(1);
        in_valid = 1'b0;
        check_eq("t3_overflow", 64'(overflow), 64'd1);
        rdy_force = 1'b1;
        g = 0;
        while (!(out_valid && out_ready && out_last) && g < 100) begin
            tick(1);
            g++;
        end
        check_eq("t3_last_seen", 64'(out_last), 64'd1);
        check_eq("t3_ready_before", 64'(in_ready), 64'd0);
        tick(1);
        check_eq("t3_ready_after", 64'(in_ready), 64'd1);
        wait_drain("t3_drain");
        check_eq("t3_count", 64'(pop_cyc.size()), 64'd32);
        check_eq("t3_sticky", 64'(overflow), 64'd1);

        // random backpressure
        pop_cyc.delete();
        burst_len = 5'd5;
        rand_rdy  = 1'b1;
        push_words(64'h300, 20);
        wait_drain("t4_drain");
        rand_rdy = 1'b0;
        check_eq("t4_count", 64'(pop_cyc.size()), 64'd20);

        // length saturation and mid-fill length change
        rdy_force = 1'b0;
        burst_len = 5'd0;
        push_words(64'h400, 15);
        check_eq("t5_len0_15", 64'(bank_full), 64'd0);
        push_words(64'h40F, 1);
        check_eq("t5_len0_16", 64'(bank_full != 2'b00), 64'd1);
        rdy_force = 1'b1;
        wait_drain("t5_len0_drain");
        rdy_force = 1'b0;
        burst_len = 5'd20;
        push_words(64'h500, 15);
        check_eq("t5_len20_15", 64'(bank_full), 64'd0);
        push_words(64'h50F, 1);
        check_eq("t5_len20_16", 64'(bank_full != 2'b00), 64'd1);
        rdy_force = 1'b1;
        wait_drain("t5_len20_drain");
        rdy_force = 1'b0;
        burst_len = 5'd8;
        push_words(64'h600, 3);
        burst_len = 5'd4;
        push_words(64'h603, 4);
        check_eq("t5_keep_len_7", 64'(bank_full), 64'd0);
        push_words(64'h607, 1);
        check_eq("t5_keep_len_8", 64'(bank_full != 2'b00), 64'd1);
        rdy_force = 1'b1;
        wait_drain("t5_change_drain");

        // reset mid-burst with output pending
        rdy_force = 1'b0;
        burst_len = 5'd3;
        push_words(64'h700, 3);
        burst_len = 5'd16;
        push_words(64'h710, 7);
        tick(2);
        check_eq("t6_pending", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        #1;
        check_eq("t6_out_valid", 64'(out_valid), 64'd0);
        check_eq("t6_out_data", out_data, 64'd0);
        check_eq("t6_out_last", 64'(out_last), 64'd0);
        check_eq("t6_bank_full", 64'(bank_full), 64'd0);
        check_eq("t6_overflow", 64'(overflow), 64'd0);
        check_eq("t6_in_ready", 64'(in_ready), 64'd1);
        burst_len = 5'd4;
        push_words(64'h800, 4);
        check_eq("t6_bank0_full", 64'(bank_full), 64'd1);
        rdy_force = 1'b1;
        wait_drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
